// File: rtl/alu_issue_stage_if.sv
// rtl/alu_issue_stage_if.sv - command, ALU operand and result bundle for alu_issue_stage
interface alu_issue_stage_if;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] in_a;
    logic [3:0] in_b;
    logic [3:0] in_sel;
    logic [3:0] alu_a;
    logic [3:0] alu_b;
    logic [3:0] alu_sel;
    logic [5:0] alu_y;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_y;
    logic [3:0] out_sel;
    logic       out_zero;
    logic       out_neg;
    logic       busy;

    modport master (
        output in_valid, in_a, in_b, in_sel, alu_y, out_ready,
        input  in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel, out_zero, out_neg, busy
    );

    modport slave (
        input  in_valid, in_a, in_b, in_sel, alu_y, out_ready,
        output in_ready, alu_a, alu_b, alu_sel, out_valid, out_y, out_sel, out_zero, out_neg, busy
    );
endinterface

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - command FIFO, registered ALU operand issue and result capture
module alu_issue_stage #(
    parameter int FIFO_DEPTH = 2,
    parameter bit ISOLATE    = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    alu_issue_stage_if.slave bus
);
    localparam int PW = (FIFO_DEPTH > 2) ? 2 : 1;
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(FIFO_DEPTH);

    typedef struct packed {
        logic [3:0] a;
        logic [3:0] b;
        logic [3:0] sel;
    } cmd_t;

    cmd_t          mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;

    logic       iss_valid;
    cmd_t       iss;
    logic       res_valid;
    logic [5:0] res_y;
    logic [3:0] res_sel;
    logic       res_zero;
    logic       res_neg;

    logic push;
    logic res_ld;
    logic iss_ld;

    // in_ready looks at FIFO occupancy only, so a full FIFO never takes a push even while popping
    assign push   = bus.in_valid && (count != FULL);
    assign res_ld = iss_valid && (!res_valid || bus.out_ready);
    assign iss_ld = (count != '0) && (!iss_valid || res_ld);

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= {bus.in_a, bus.in_b, bus.in_sel};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (iss_ld) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, iss_ld})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Operands only move on a real issue; idle keeps them frozen (or zeroed) so the ALU stays quiet
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_valid <= 1'b0;
            iss       <= '0;
        end else if (iss_ld) begin
            iss_valid <= 1'b1;
            iss       <= mem[rd_ptr];
        end else if (res_ld) begin
            iss_valid <= 1'b0;
            if (!ISOLATE) begin
                iss <= '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            res_valid <= 1'b0;
            res_y     <= '0;
            res_sel   <= '0;
            res_zero  <= 1'b1;
            res_neg   <= 1'b0;
        end else if (res_ld) begin
            res_valid <= 1'b1;
            res_y     <= bus.alu_y;
            res_sel   <= iss.sel;
            res_zero  <= (bus.alu_y == 6'd0);
            res_neg   <= bus.alu_y[5];
        end else if (res_valid && bus.out_ready) begin
            res_valid <= 1'b0;
        end
    end

    assign bus.in_ready  = (count != FULL);
    assign bus.alu_a     = iss.a;
    assign bus.alu_b     = iss.b;
    assign bus.alu_sel   = iss.sel;
    assign bus.out_valid = res_valid;
    assign bus.out_y     = res_y;
    assign bus.out_sel   = res_sel;
    assign bus.out_zero  = res_zero;
    assign bus.out_neg   = res_neg;
    assign bus.busy      = (count != '0) || iss_valid || res_valid;
endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- Upstream issue and result-capture stage for the 4-bit configurable ALU (Sel[3]=0 arithmetic, Sel[3]=1 logical; 4-bit signed A/B in, 6-bit Y out).
- Accepts commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives registered, operand-isolated A/B/Sel into the combinational ALU. Registered operands stop input toggles from reaching the ALU when idle.
- Captures the ALU's Y one cycle later and presents it downstream with status flags over a second valid/ready handshake.

Parameters:
- FIFO_DEPTH, 2, command FIFO entries; legal values 2 or 4.
- ISOLATE, 1, idle operand policy: 1 holds the last issued A/B/Sel when idle (zero toggling); 0 drives zeros when idle.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  command present.
- in_ready  output  1  command FIFO can accept.
- in_a  input  4  operand A (signed).
- in_b  input  4  operand B (signed).
- in_sel  input  4  ALU opcode.
- alu_a  output  4  registered A to the ALU.
- alu_b  output  4  registered B to the ALU.
- alu_sel  output  4  registered Sel to the ALU.
- alu_y  input  6  combinational ALU result.
- out_valid  output  1  result register full.
- out_ready  input  1  downstream accepts the result.
- out_y  output  6  captured result.
- out_sel  output  4  opcode that produced out_y.
- out_zero  output  1  out_y == 0.
- out_neg  output  1  out_y[5].
- busy  output  1  any of FIFO, issue reg or result reg occupied.

Behaviour:
- Reset (asynchronous, active-high on rst):
  - FIFO is emptied and pointers/count are cleared.
  - iss_valid=0, out_valid=0.
  - alu_a, alu_b, alu_sel = 0; out_y=0, out_sel=0, out_zero=1, out_neg=0.
  - in_ready=1, busy=0.
  - Reset mid-operation discards all in-flight commands. No result is emitted for them.
- Push: occurs when in_valid && in_ready. in_ready = (count != FIFO_DEPTH), depending on FIFO state only.
  - There is no fall-through. A push when full is impossible, even if a pop happens in the same cycle.
- Pipeline: FIFO -> issue register (iss_valid, drives alu_*) -> result register (out_valid).
- Result-load enable: res_ld = iss_valid && (!out_valid || out_ready).
- Issue-load enable: iss_ld = (count != 0) && (!iss_valid || res_ld).
  - On iss_ld: FIFO head is popped into alu_a/alu_b/alu_sel and iss_valid=1.
  - If res_ld && !iss_ld: iss_valid=0.
  - When iss_valid=0 with ISOLATE=1, alu_* hold their last values. With ISOLATE=0, alu_* are 0 on the edge iss_valid falls.
- On res_ld: out_y<=alu_y, out_sel<=alu_sel, out_zero<=(alu_y==0), out_neg<=alu_y[5], out_valid<=1.
- If out_valid && out_ready && !res_ld: out_valid<=0. out_y and flags hold their values.
- Latency: a command accepted at edge T is in alu_* at edge T+1 (earliest) and in out_y with out_valid at edge T+2. This is 2 cycles.
- Throughput: 1 command/cycle sustained while out_ready=1.
- Backpressure with out_ready=0:
  - The result register holds and the issue register holds; alu_* stay stable, so the ALU does not toggle.
  - The FIFO fills, then in_ready=0.
  - Total in-flight capacity = FIFO_DEPTH + 2.
- Simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Commands are delivered in strict order. None are dropped or duplicated.
- busy = (count!=0) || iss_valid || out_valid.
- The block has no knowledge of opcode semantics. It treats alu_y as opaque 6 bits and assumes the ALU settles within one cycle.

Test Plan (bench instantiates the real ALU between alu_* and alu_y):
- Reset values: assert rst mid-stream with 3 commands in flight -> all outputs immediately at their reset values, in_ready=1, busy=0. No out_valid follows after release.
- Single command: push A=3, B=2, Sel=0110 at edge T -> alu_a=3 at T+1. At T+2: out_valid=1, out_y=6'd5, out_sel=0110, out_zero=0, out_neg=0.
- Back-to-back stream with out_ready=1:
  - Push A=7/Sel=0000, then A=0/Sel=1000, then A=1/B=-1/Sel=0110 on consecutive edges.
  - Required: out_y=8, then 6'b111111 with out_neg=1, then 0 with out_zero=1, on 3 consecutive cycles.
- Backpressure (FIFO_DEPTH=2): out_ready=0, push continuously -> exactly 4 accepts, then in_ready=0. alu_* are constant while stalled.
  - Then out_ready=1 -> 4 results in push order on consecutive cycles, and in_ready=1 again after the first drain.
- Isolation: ISOLATE=1, idle after A=5/B=6/Sel=1010 -> alu_* remain 5/6/1010. With ISOLATE=0 -> alu_* become 0 the edge after the issue register empties.
- Full with simultaneous drain: FIFO full, out_ready toggling 1/0 each cycle while in_valid=1 -> no push while in_ready=0. Order is preserved and the result count equals the accept count.
